usb_rx_packet_decoder: RTL and testbench
========================================

// Module: usb_rx_packet_decoder
// PURPOSE
//  Full-speed USB receive path, counterpart of usb_tx. Takes already-synchronised D+/D- samples at one strobe per
//  bit time. Decodes SYNC, NRZI, bit unstuffing and EOP, and assembles LSB-first bytes into a small FIFO.
//  The FIFO feeds the clk48-synchronous backend byte handshake (rxAcceptNewData/rxDataValid/rxIsLastByte/keepPacket).
// PARAMETERS
//  BUF_DEPTH       4  FIFO entries {keep,isLast,data[7:0]}; power of 2, >=2
//  SYNC_MIN_ZEROS  5  decoded 0s required before the SYNC-terminating 1 (tolerates hub-truncated SYNC)
//  EOP_MIN_SE0     2  consecutive SE0 bit times that qualify an EOP
// PORTS
//  clk48            in   1  system clock, 48 MHz; single clock domain
//  rxRST_n          in   1  asynchronous, active-low reset
//  rxBitValid       in   1  one-cycle strobe marking a bit-time sample, at most 1 per 4 cycles
//  dataInP          in   1  sampled D+ (valid when rxBitValid)
//  dataInN          in   1  sampled D- (valid when rxBitValid)
//  rxAcceptNewData  in   1  backend pops the head byte this cycle (ignored when FIFO is empty)
//  rxData           out  8  FIFO head data
//  rxDataValid      out  1  FIFO not empty
//  rxIsLastByte     out  1  head byte is the packet's last byte
//  keepPacket       out  1  head's keep flag; meaningful only when rxDataValid&&rxIsLastByte
//  receiving        out  1  high from SYNC detection until the EOP/abort completes
//  rxOverflow       out  1  one-cycle pulse when a push is discarded because the FIFO is full
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; state IDLE; prevLine=J; all counters 0. All logic advances only on rxBitValid,
//   except FIFO pop and rxOverflow.
//  Line: J=P1N0, K=P0N1, SE0=P0N0, SE1=P1N1.
//  NRZI: decoded bit = 1 if line equals prevLine, else 0. prevLine is updated on every non-SE0 sample.
//  State IDLE: on K -> SYNC, zeroCnt=1.
//  State SYNC: decoded 0 -> zeroCnt++ (saturating).
//   - Decoded 1 with zeroCnt>=SYNC_MIN_ZEROS -> DATA, receiving=1, onesCnt=1, bitCnt=0, err=0, pendValid=0.
//   - Decoded 1 with a short zero run -> IDLE.
//   - SE0/SE1 -> IDLE.
//  State DATA:
//   - Decoded 1 -> onesCnt++.
//   - Decoded 0 -> onesCnt=0.
//   - When onesCnt==6, the next bit is a stuff bit: a 0 is dropped and onesCnt=0; a 1 sets err and goes to DROP.
//   - Non-stuff bits shift into shreg[7] (LSB first) and bitCnt++.
//   - bitCnt wrapping 7->0 completes a byte. If pendValid, the old pending byte is pushed {keep=1,isLast=0}.
//     The new byte then becomes pending and pendValid=1.
//   - SE1 -> err, DROP. SE0 -> EOP with se0Cnt=1.
//  State EOP: SE0 -> se0Cnt++ (saturating).
//   - J with se0Cnt>=EOP_MIN_SE0 is the end of packet. If pendValid, push pending {keep=!err&&bitCnt==0, isLast=1}.
//     Then go to IDLE with receiving=0.
//   - J with a short SE0 run, K, or SE1 -> err, DROP.
//  State DROP: waits for a qualified EOP (>=EOP_MIN_SE0 SE0s, then J).
//   - Pushes pending {keep=0,isLast=1} if pendValid; a packet with no completed byte pushes nothing.
//   - Then IDLE with receiving=0.
//   - No other push while in DROP.
//  FIFO: push is registered, so rxDataValid rises the cycle after the push. Pop when rxAcceptNewData&&rxDataValid.
//   - Push and pop in the same cycle are both honoured, including when full.
//   - A push when full (and no pop) is discarded, pulses rxOverflow, and sets err for the current packet.
//  Latency: byte N appears when byte N+1 completes (last byte: at EOP J) + 1 cycle.
//  rxRST_n asserted mid-packet: immediate return to the reset state; FIFO contents are discarded.
// TESTING
//  1 Reset: hold rxRST_n=0 with random line -> all outputs 0; release with line J -> still idle, no valid.
//  2 SYNC KJKJKJKK, bytes C3 01 02, SE0 SE0 J, accept=1 -> C3,01 (last=0), then 02 (last=1, keep=1); receiving drops after J.
//  3 Bytes FF FF with stuffed 0s -> FF FF, keep=1.
//    Same stream with the 2nd stuff bit forced to 1 -> head FF last=1 keep=0, nothing further.
//  4 SYNC + A5 + 3 extra bits + EOP -> single byte A5, last=1, keep=0.
//  5 BUF_DEPTH=4, accept=0, 6-byte packet 01..06 -> one rxOverflow pulse at byte 6 completion (byte 05 dropped).
//    EOP push of byte 06 is also dropped (second rxOverflow pulse). FIFO holds 01..04 with last=0, none marked last.
//  6 SE1 mid-byte, then EOP -> previous complete byte last=1 keep=0.
//    Reset asserted mid-packet -> rxDataValid=0 next cycle.
//    A clean packet afterwards decodes correctly.

Source files
------------

// File: rtl/usb_rx_packet_decoder_if.sv
// Byte-side and line-side bundle for the USB receive decoder.
// Master drives bit samples and pops; slave returns FIFO head and status.
interface usb_rx_packet_decoder_if;
  logic       rxBitValid;
  logic       dataInP;
  logic       dataInN;
  logic       rxAcceptNewData;
  logic [7:0] rxData;
  logic       rxDataValid;
  logic       rxIsLastByte;
  logic       keepPacket;
  logic       receiving;
  logic       rxOverflow;

  modport master (
    output rxBitValid,
    output dataInP,
    output dataInN,
    output rxAcceptNewData,
    input  rxData,
    input  rxDataValid,
    input  rxIsLastByte,
    input  keepPacket,
    input  receiving,
    input  rxOverflow
  );

  modport slave (
    input  rxBitValid,
    input  dataInP,
    input  dataInN,
    input  rxAcceptNewData,
    output rxData,
    output rxDataValid,
    output rxIsLastByte,
    output keepPacket,
    output receiving,
    output rxOverflow
  );
endinterface

// File: rtl/usb_rx_packet_decoder.sv
// Full-speed USB receive path: SYNC, NRZI, unstuffing, EOP,
// byte assembly and a small output FIFO with keep/last flags.
module usb_rx_packet_decoder #(
  parameter int BUF_DEPTH      = 4,
  parameter int SYNC_MIN_ZEROS = 5,
  parameter int EOP_MIN_SE0    = 2
) (
  input logic                   clk48,
  input logic                   rxRST_n,
  usb_rx_packet_decoder_if.slave bus
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int ZW = $clog2(SYNC_MIN_ZEROS + 1);
  localparam int EW = $clog2(EOP_MIN_SE0 + 1);

  typedef enum logic [2:0] {
    IDLE, SYNC, DATA, EOP, DROP
  } state_t;

  typedef struct packed {
    logic       keep;
    logic       isLast;
    logic [7:0] data;
  } entry_t;

  state_t        state, stateN;
  logic          prevLine, prevLineN;
  logic [ZW-1:0] zeroCnt, zeroN;
  logic [EW-1:0] se0Cnt, se0N;
  logic [2:0]    onesCnt, onesN;
  logic [2:0]    bitCnt, bitCntN;
  logic [7:0]    shreg, shregN;
  logic [7:0]    pend, pendN;
  logic          pendValid, pendValidN;
  logic          err, errN;

  logic          pushReq;
  entry_t        pushWord;
  logic          ovfHit;

  entry_t        mem [BUF_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic          ovfReg;

  logic lineJ, lineK, lineSe0, lineSe1, dbit;
  logic full, empty, pop, doWrite;

  assign lineJ   =  bus.dataInP & ~bus.dataInN;
  assign lineK   = ~bus.dataInP &  bus.dataInN;
  assign lineSe0 = ~bus.dataInP & ~bus.dataInN;
  assign lineSe1 =  bus.dataInP &  bus.dataInN;
  assign dbit    = (bus.dataInP == prevLine);

  assign empty   = (count == '0);
  assign full    = (count == CW'(BUF_DEPTH));
  assign pop     = bus.rxAcceptNewData && !empty;
  assign doWrite = pushReq && (!full || pop);

  // Decoder state register.
  always_ff @(posedge clk48 or negedge rxRST_n) begin
    if (!rxRST_n) begin
      state     <= IDLE;
      prevLine  <= 1'b1;
      zeroCnt   <= '0;
      se0Cnt    <= '0;
      onesCnt   <= '0;
      bitCnt    <= '0;
      shreg     <= '0;
      pend      <= '0;
      pendValid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= stateN;
      prevLine  <= prevLineN;
      zeroCnt   <= zeroN;
      se0Cnt    <= se0N;
      onesCnt   <= onesN;
      bitCnt    <= bitCntN;
      shreg     <= shregN;
      pend      <= pendN;
      pendValid <= pendValidN;
      err       <= errN;
    end
  end

  // Per-bit decode: line state, SYNC/EOP qualification, unstuffing, pushes.
  always_comb begin
    stateN     = state;
    prevLineN  = prevLine;
    zeroN      = zeroCnt;
    se0N       = se0Cnt;
    onesN      = onesCnt;
    bitCntN    = bitCnt;
    shregN     = shreg;
    pendN      = pend;
    pendValidN = pendValid;
    errN       = err;
    pushReq    = 1'b0;
    pushWord   = '0;
    ovfHit     = 1'b0;

    if (bus.rxBitValid) begin
      if (!lineSe0) prevLineN = bus.dataInP;
      unique case (state)
        IDLE: begin
          if (lineK) begin
            stateN = SYNC;
            zeroN  = ZW'(1);
          end
        end
        SYNC: begin
          if (lineSe0 || lineSe1) begin
            stateN = IDLE;
          end else if (!dbit) begin
            if (zeroCnt != ZW'(SYNC_MIN_ZEROS))
              zeroN = zeroCnt + 1'b1;
          end else if (zeroCnt >= ZW'(SYNC_MIN_ZEROS)) begin
            stateN     = DATA;
            onesN      = 3'd1;
            bitCntN    = 3'd0;
            errN       = 1'b0;
            pendValidN = 1'b0;
          end else begin
            stateN = IDLE;
          end
        end
        DATA: begin
          unique case (1'b1)
            lineSe1: begin
              errN   = 1'b1;
              stateN = DROP;
              se0N   = '0;
            end
            lineSe0: begin
              stateN = EOP;
              se0N   = EW'(1);
            end
            (onesCnt == 3'd6): begin
              if (dbit) begin
                errN   = 1'b1;
                stateN = DROP;
                se0N   = '0;
              end else begin
                onesN = 3'd0;
              end
            end
            default: begin
              onesN   = dbit ? onesCnt + 1'b1 : 3'd0;
              shregN  = {dbit, shreg[7:1]};
              bitCntN = bitCnt + 1'b1;
              if (bitCnt == 3'd7) begin
                if (pendValid) begin
                  pushReq  = 1'b1;
                  pushWord = '{keep: 1'b1, isLast: 1'b0, data: pend};
                end
                pendN      = {dbit, shreg[7:1]};
                pendValidN = 1'b1;
              end
            end
          endcase
        end
        EOP: begin
          if (lineSe0) begin
            if (se0Cnt != EW'(EOP_MIN_SE0))
              se0N = se0Cnt + 1'b1;
          end else if (lineJ && se0Cnt >= EW'(EOP_MIN_SE0)) begin
            if (pendValid) begin
              pushReq  = 1'b1;
              pushWord = '{keep: !err && bitCnt == 3'd0,
                           isLast: 1'b1, data: pend};
            end
            pendValidN = 1'b0;
            stateN     = IDLE;
          end else begin
            errN   = 1'b1;
            stateN = DROP;
            se0N   = '0;
          end
        end
        DROP: begin
          if (lineSe0) begin
            if (se0Cnt != EW'(EOP_MIN_SE0))
              se0N = se0Cnt + 1'b1;
          end else if (lineJ && se0Cnt >= EW'(EOP_MIN_SE0)) begin
            if (pendValid) begin
              pushReq  = 1'b1;
              pushWord = '{keep: 1'b0, isLast: 1'b1, data: pend};
            end
            pendValidN = 1'b0;
            stateN     = IDLE;
          end else begin
            se0N = '0;
          end
        end
        default: stateN = IDLE;
      endcase
    end

    if (pushReq && full && !pop) begin
      ovfHit = 1'b1;
      errN   = 1'b1;
    end
  end

  // Output FIFO; a pop frees the slot a same-cycle push needs.
  always_ff @(posedge clk48 or negedge rxRST_n) begin
    if (!rxRST_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      ovfReg <= 1'b0;
    end else begin
      ovfReg <= ovfHit;
      if (doWrite) begin
        mem[wrPtr] <= pushWord;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(doWrite) - CW'(pop);
    end
  end

  assign bus.rxData       = mem[rdPtr].data;
  assign bus.rxDataValid  = !empty;
  assign bus.rxIsLastByte = !empty && mem[rdPtr].isLast;
  assign bus.keepPacket   = !empty && mem[rdPtr].keep;
  assign bus.receiving    = (state == DATA) || (state == EOP) ||
                            (state == DROP);
  assign bus.rxOverflow   = ovfReg;

endmodule

// File: tb/tb_usb_rx_packet_decoder.sv
// Bench for usb_rx_packet_decoder: NRZI/stuffing encoder drives
// packets, a scoreboard queue checks bytes as they are popped.
module tb_usb_rx_packet_decoder;

  logic clk48 = 1'b0;
  logic rst_n;

  always #5 clk48 = ~clk48;

  usb_rx_packet_decoder_if bus ();

  usb_rx_packet_decoder #(
    .BUF_DEPTH(4),
    .SYNC_MIN_ZEROS(5),
    .EOP_MIN_SE0(2)
  ) dut (
    .clk48(clk48),
    .rxRST_n(rst_n),
    .bus(bus)
  );

  int nTests = 0;
  int nFail  = 0;
  int ovfCnt = 0;

  logic [9:0] expQ[$];

  logic txPrev;
  int   ones;
  int   stuffIdx;
  int   corruptIdx = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ent(input logic keep, input logic last,
                                     input logic [7:0] d);
    return {keep, last, d};
  endfunction

  // Scoreboard: compare each popped head against the oldest expectation.
  always @(negedge clk48) begin
    if (rst_n && bus.rxDataValid && bus.rxAcceptNewData) begin
      if (expQ.size() == 0) begin
        chk("qHasEntry", 32'(expQ.size()), 32'd1);
      end else begin
        chk("byte", {bus.keepPacket, bus.rxIsLastByte, bus.rxData},
            expQ.pop_front());
      end
    end
    if (bus.rxOverflow) ovfCnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic sendLine(input logic p, input logic n);
    @(posedge clk48);
    #1;
    bus.dataInP    = p;
    bus.dataInN    = n;
    bus.rxBitValid = 1'b1;
    @(posedge clk48);
    #1;
    bus.rxBitValid = 1'b0;
    repeat (3) @(posedge clk48);
  endtask

  task automatic sendRaw(input logic b);
    if (!b) txPrev = ~txPrev;
    sendLine(txPrev, ~txPrev);
  endtask

  task automatic sendBit(input logic b);
    sendRaw(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      stuffIdx++;
      sendRaw(stuffIdx == corruptIdx);
      ones = 0;
    end
  endtask

  task automatic sendByte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) sendBit(d[i]);
  endtask

  task automatic sendSync();
    for (int i = 0; i < 8; i++) begin
      logic p;
      p = (i < 7) ? logic'(i % 2) : 1'b0;
      sendLine(p, ~p);
    end
    txPrev   = 1'b0;
    ones     = 1;
    stuffIdx = 0;
  endtask

  task automatic sendEop();
    sendLine(1'b0, 1'b0);
    sendLine(1'b0, 1'b0);
    sendLine(1'b1, 1'b0);
    txPrev = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && expQ.size() != 0; i++)
      @(posedge clk48);
    chk(tag, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.rxBitValid      = 1'b0;
    bus.dataInP         = 1'b1;
    bus.dataInN         = 1'b0;
    bus.rxAcceptNewData = 1'b0;
    txPrev              = 1'b1;
    ones                = 0;
    stuffIdx            = 0;

    // Reset with a random line.
    repeat (20) begin
      @(posedge clk48);
      #1;
      bus.dataInP         = 1'($urandom);
      bus.dataInN         = 1'($urandom);
      bus.rxBitValid      = 1'($urandom);
      bus.rxAcceptNewData = 1'($urandom);
    end
    @(negedge clk48);
    chk("rstOut", {bus.rxData, bus.rxDataValid, bus.rxIsLastByte,
                   bus.keepPacket, bus.receiving, bus.rxOverflow}, 0);
    @(posedge clk48);
    #1;
    bus.rxBitValid      = 1'b0;
    bus.dataInP         = 1'b1;
    bus.dataInN         = 1'b0;
    bus.rxAcceptNewData = 1'b0;
    rst_n               = 1'b1;
    repeat (3) sendLine(1'b1, 1'b0);
    @(negedge clk48);
    chk("idleOut", {bus.rxDataValid, bus.receiving}, 0);

    // Basic three-byte packet.
    bus.rxAcceptNewData = 1'b1;
    expQ.push_back(ent(1, 0, 8'hC3));
    expQ.push_back(ent(1, 0, 8'h01));
    expQ.push_back(ent(1, 1, 8'h02));
    sendSync();
    @(negedge clk48);
    chk("rcvSync", bus.receiving, 1);
    sendByte(8'hC3);
    sendByte(8'h01);
    sendByte(8'h02);
    @(negedge clk48);
    chk("rcvData", bus.receiving, 1);
    sendEop();
    @(negedge clk48);
    chk("rcvEop", bus.receiving, 0);
    drain("drainBasic");

    // All-ones bytes exercise unstuffing.
    expQ.push_back(ent(1, 0, 8'hFF));
    expQ.push_back(ent(1, 1, 8'hFF));
    sendSync();
    sendByte(8'hFF);
    sendByte(8'hFF);
    sendEop();
    drain("drainStuff");

    // Second stuff bit violated.
    corruptIdx = 2;
    expQ.push_back(ent(0, 1, 8'hFF));
    sendSync();
    sendByte(8'hFF);
    sendByte(8'hFF);
    sendEop();
    corruptIdx = 0;
    drain("drainBadStuff");
    repeat (4) sendLine(1'b1, 1'b0);
    @(negedge clk48);
    chk("badStuffEmpty", bus.rxDataValid, 0);

    // Trailing partial byte clears keep.
    expQ.push_back(ent(0, 1, 8'hA5));
    sendSync();
    sendByte(8'hA5);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    sendEop();
    drain("drainPartial");

    // Overflow with backend stalled.
    bus.rxAcceptNewData = 1'b0;
    ovfCnt = 0;
    sendSync();
    for (int i = 1; i <= 6; i++) sendByte(8'(i));
    sendEop();
    @(negedge clk48);
    chk("ovfPulses", 32'(ovfCnt), 32'd2);
    chk("ovfValid", bus.rxDataValid, 1);
    chk("ovfHeadLast", bus.rxIsLastByte, 0);
    for (int i = 1; i <= 4; i++) expQ.push_back(ent(1, 0, 8'(i)));
    @(posedge clk48);
    #1;
    bus.rxAcceptNewData = 1'b1;
    drain("drainOvf");
    @(negedge clk48);
    chk("ovfEmpty", bus.rxDataValid, 0);

    // SE1 in mid-byte aborts the packet.
    expQ.push_back(ent(0, 1, 8'h5A));
    sendSync();
    sendByte(8'h5A);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    sendLine(1'b1, 1'b1);
    sendEop();
    drain("drainSe1");

    // Reset in mid-packet discards the FIFO.
    bus.rxAcceptNewData = 1'b0;
    sendSync();
    sendByte(8'h11);
    sendByte(8'h22);
    sendByte(8'h33);
    @(negedge clk48);
    chk("preRstValid", bus.rxDataValid, 1);
    @(posedge clk48);
    #1;
    rst_n = 1'b0;
    @(negedge clk48);
    chk("midRstOut", {bus.rxDataValid, bus.receiving}, 0);
    @(posedge clk48);
    #1;
    bus.dataInP = 1'b1;
    bus.dataInN = 1'b0;
    txPrev      = 1'b1;
    rst_n       = 1'b1;
    bus.rxAcceptNewData = 1'b1;
    repeat (2) sendLine(1'b1, 1'b0);
    @(negedge clk48);
    chk("postRstEmpty", bus.rxDataValid, 0);

    // Clean packet after reset, with a stuff bit inside 7E.
    expQ.push_back(ent(1, 0, 8'h7E));
    expQ.push_back(ent(1, 1, 8'h81));
    sendSync();
    sendByte(8'h7E);
    sendByte(8'h81);
    sendEop();
    drain("drainClean");
    repeat (2) sendLine(1'b1, 1'b0);
    @(negedge clk48);
    chk("finalEmpty", {bus.rxDataValid, bus.receiving}, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
